// File: rtl/wshb_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter for the SDRAM frame-buffer port.
// Round-robin ownership, burst-limited tenure with drain-before-handover preemption.
module wshb_arbiter #(
    parameter int MAX_BURST = 64,
    parameter int MAX_PEND  = 8,
    parameter int ADR_W     = 32,
    parameter int DAT_W     = 32,
    parameter int SEL_W     = DAT_W / 8
) (
    input  logic             clk,
    input  logic             rst,
    // master 0 (pixel writer)
    input  logic             s0_cyc_i,
    input  logic             s0_stb_i,
    input  logic             s0_we_i,
    input  logic [SEL_W-1:0] s0_sel_i,
    input  logic [ADR_W-1:0] s0_adr_i,
    input  logic [DAT_W-1:0] s0_dat_i,
    input  logic [2:0]       s0_cti_i,
    input  logic [1:0]       s0_bte_i,
    output logic             s0_ack_o,
    output logic             s0_stall_o,
    output logic [DAT_W-1:0] s0_dat_o,
    // master 1 (display reader)
    input  logic             s1_cyc_i,
    input  logic             s1_stb_i,
    input  logic             s1_we_i,
    input  logic [SEL_W-1:0] s1_sel_i,
    input  logic [ADR_W-1:0] s1_adr_i,
    input  logic [DAT_W-1:0] s1_dat_i,
    input  logic [2:0]       s1_cti_i,
    input  logic [1:0]       s1_bte_i,
    output logic             s1_ack_o,
    output logic             s1_stall_o,
    output logic [DAT_W-1:0] s1_dat_o,
    // shared slave (SDRAM controller)
    output logic             m_cyc_o,
    output logic             m_stb_o,
    output logic             m_we_o,
    output logic [SEL_W-1:0] m_sel_o,
    output logic [ADR_W-1:0] m_adr_o,
    output logic [DAT_W-1:0] m_dat_o,
    output logic [2:0]       m_cti_o,
    output logic [1:0]       m_bte_o,
    input  logic             m_ack_i,
    input  logic             m_stall_i,
    input  logic [DAT_W-1:0] m_dat_i,
    output logic [1:0]       grant
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int PW = $clog2(MAX_PEND + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

    state_t          state_q;
    logic            owner_q;
    logic            last_q;
    logic [1:0]      grant_q;
    logic [BW-1:0]   burst_q, burst_d;
    logic [PW-1:0]   pend_q, pend_d;

    logic owning, draining, active;
    logic own_cyc, own_stb, oth_cyc;
    logic pend_full, accept, ack_ok, preempt;
    logic [1:0] ack_v, stall_v;

    assign owning    = (state_q == OWN0) || (state_q == OWN1);
    assign draining  = (state_q == DRAIN);
    assign active    = owning || draining;

    assign own_cyc   = owner_q ? s1_cyc_i : s0_cyc_i;
    assign own_stb   = owner_q ? s1_stb_i : s0_stb_i;
    assign oth_cyc   = owner_q ? s0_cyc_i : s1_cyc_i;
    assign pend_full = (pend_q == PW'(MAX_PEND));

    // Slave request side follows the registered owner only.
    assign m_cyc_o = owning ? own_cyc : (draining && (pend_q != '0));
    assign m_stb_o = owning && own_stb && !pend_full;
    assign m_we_o  = owner_q ? s1_we_i  : s0_we_i;
    assign m_sel_o = owner_q ? s1_sel_i : s0_sel_i;
    assign m_adr_o = owner_q ? s1_adr_i : s0_adr_i;
    assign m_dat_o = owner_q ? s1_dat_i : s0_dat_i;
    assign m_cti_o = owner_q ? s1_cti_i : s0_cti_i;
    assign m_bte_o = owner_q ? s1_bte_i : s0_bte_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign ack_v[gi]   = active && (owner_q == 1'(gi)) && m_ack_i;
            assign stall_v[gi] = !(owning && (owner_q == 1'(gi))) || m_stall_i || pend_full;
        end
    endgenerate

    assign s0_ack_o   = ack_v[0];
    assign s1_ack_o   = ack_v[1];
    assign s0_stall_o = stall_v[0];
    assign s1_stall_o = stall_v[1];
    assign s0_dat_o   = m_dat_i;
    assign s1_dat_o   = m_dat_i;
    assign grant      = grant_q;

    assign accept = m_stb_o && !m_stall_i;
    // Stray acks with nothing outstanding are dropped so pend never underflows.
    assign ack_ok = active && m_ack_i && (pend_q != '0);

    always_comb begin
        pend_d = pend_q;
        if (accept && !ack_ok)
            pend_d = pend_q + PW'(1);
        else if (!accept && ack_ok)
            pend_d = pend_q - PW'(1);
        burst_d = burst_q;
        if (accept && (burst_q < BW'(MAX_BURST)))
            burst_d = burst_q + BW'(1);
    end

    // Look at the post-accept burst count so the accept that hits the limit is the last one.
    assign preempt = owning && oth_cyc && (burst_d >= BW'(MAX_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
            burst_q <= '0;
            pend_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    burst_q <= '0;
                    pend_q  <= '0;
                    if (s0_cyc_i && (!s1_cyc_i || last_q)) begin
                        state_q <= OWN0;
                        owner_q <= 1'b0;
                        grant_q <= 2'b01;
                    end else if (s1_cyc_i) begin
                        state_q <= OWN1;
                        owner_q <= 1'b1;
                        grant_q <= 2'b10;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        last_q  <= owner_q;
                        grant_q <= 2'b00;
                        burst_q <= '0;
                        pend_q  <= '0;
                    end else begin
                        burst_q <= burst_d;
                        pend_q  <= pend_d;
                        if (preempt)
                            state_q <= DRAIN;
                    end
                end
                default: begin
                    if (!own_cyc || (pend_q == '0)) begin
                        last_q  <= owner_q;
                        burst_q <= '0;
                        pend_q  <= '0;
                        if (own_cyc && oth_cyc) begin
                            state_q <= owner_q ? OWN0 : OWN1;
                            owner_q <= !owner_q;
                            grant_q <= owner_q ? 2'b01 : 2'b10;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= 2'b00;
                        end
                    end else begin
                        pend_q <= pend_d;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: behavioural masters and a fixed-latency slave
// stepped from one initial block, checked with immediate assertions.
module tb_wshb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        s0_cyc_i, s0_stb_i, s0_we_i, s1_cyc_i, s1_stb_i, s1_we_i;
    logic [3:0]  s0_sel_i, s1_sel_i, m_sel_o;
    logic [31:0] s0_adr_i, s0_dat_i, s1_adr_i, s1_dat_i;
    logic [2:0]  s0_cti_i, s1_cti_i, m_cti_o;
    logic [1:0]  s0_bte_i, s1_bte_i, m_bte_o;
    logic        s0_ack_o, s0_stall_o, s1_ack_o, s1_stall_o;
    logic [31:0] s0_dat_o, s1_dat_o;
    logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i, m_stall_i;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_err = 0;

    int   left[2], mpend[2], macks[2], maccs[2];
    bit   auto_en[2];
    int   slv_accs, slv_acks, lat;
    bit   ack_en;
    logic [7:0] pipe;

    always #5 clk = ~clk;

    wshb_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_cyc_i(s0_cyc_i), .s0_stb_i(s0_stb_i), .s0_we_i(s0_we_i), .s0_sel_i(s0_sel_i),
        .s0_adr_i(s0_adr_i), .s0_dat_i(s0_dat_i), .s0_cti_i(s0_cti_i), .s0_bte_i(s0_bte_i),
        .s0_ack_o(s0_ack_o), .s0_stall_o(s0_stall_o), .s0_dat_o(s0_dat_o),
        .s1_cyc_i(s1_cyc_i), .s1_stb_i(s1_stb_i), .s1_we_i(s1_we_i), .s1_sel_i(s1_sel_i),
        .s1_adr_i(s1_adr_i), .s1_dat_i(s1_dat_i), .s1_cti_i(s1_cti_i), .s1_bte_i(s1_bte_i),
        .s1_ack_o(s1_ack_o), .s1_stall_o(s1_stall_o), .s1_dat_o(s1_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_cti_o(m_cti_o), .m_bte_o(m_bte_o),
        .m_ack_i(m_ack_i), .m_stall_i(m_stall_i), .m_dat_i(m_dat_i),
        .grant(grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_cyc(input int i);
        return (i == 0) ? s0_cyc_i : s1_cyc_i;
    endfunction

    task automatic set_m(input int i, input logic c, input logic s);
        if (i == 0) begin s0_cyc_i = c; s0_stb_i = s; end
        else        begin s1_cyc_i = c; s1_stb_i = s; end
    endtask

    task automatic start(input int i, input int n);
        left[i] = n;
        set_m(i, 1'b1, n > 0);
    endtask

    task automatic upd(input int i, input logic acc, input logic ack);
        if (acc) begin left[i]--; mpend[i]++; maccs[i]++; end
        if (ack) begin mpend[i]--; macks[i]++; end
        if (get_cyc(i)) begin
            if (left[i] == 0 && mpend[i] == 0) set_m(i, 1'b0, 1'b0);
            else set_m(i, 1'b1, left[i] > 0);
        end else if (auto_en[i]) begin
            start(i, 4);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; mpend[i] = 0; macks[i] = 0; maccs[i] = 0; auto_en[i] = 1'b0;
            set_m(i, 1'b0, 1'b0);
        end
        slv_accs = 0; slv_acks = 0; pipe = '0; m_ack_i = 1'b0;
    endtask

    // One clock: sample handshakes before the edge, update models after it.
    task automatic step();
        logic a0, a1, k0, k1, sa;
        #1;
        a0 = s0_cyc_i & s0_stb_i & ~s0_stall_o;
        a1 = s1_cyc_i & s1_stb_i & ~s1_stall_o;
        k0 = s0_ack_o;
        k1 = s1_ack_o;
        sa = m_cyc_o & m_stb_o & ~m_stall_i;
        if (m_ack_i) slv_acks++;
        @(posedge clk);
        #1;
        if (sa) slv_accs++;
        pipe = {pipe[6:0], sa};
        m_ack_i = ack_en ? pipe[lat-1] : 1'b0;
        upd(0, a0, k0);
        upd(1, a1, k1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mreset();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drop(input int i, input int bound, input string tag);
        int n = 0;
        while (get_cyc(i) && n < bound) begin step(); n++; end
        chk(tag, 32'(n < bound), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen, bad1, a_at;
        logic [1:0] prev;
        logic [1:0] gl[4];

        rst = 1'b1;
        s0_we_i = 1'b1; s0_sel_i = 4'hf; s0_adr_i = 32'h1000; s0_dat_i = 32'h1111_0000;
        s0_cti_i = 3'd0; s0_bte_i = 2'd0;
        s1_we_i = 1'b0; s1_sel_i = 4'hf; s1_adr_i = 32'h2000; s1_dat_i = 32'h2222_0000;
        s1_cti_i = 3'd0; s1_bte_i = 2'd0;
        m_stall_i = 1'b0; m_dat_i = 32'hCAFE_0000; lat = 1; ack_en = 1'b1;
        mreset();
        step();
        step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_stall0", 32'(s0_stall_o), 32'd1);
        chk("rst_stall1", 32'(s1_stall_o), 32'd1);
        chk("rst_ack0", 32'(s0_ack_o), 32'd0);
        chk("rst_ack1", 32'(s1_ack_o), 32'd0);
        chk("rst_mcyc", 32'(m_cyc_o), 32'd0);
        chk("rst_mstb", 32'(m_stb_o), 32'd0);
        rst = 1'b0;
        step();

        // Single master, 10 writes, ack latency 1.
        start(0, 10);
        #1;
        chk("t1_grant_idle", 32'(grant), 32'd0);
        step();
        chk("t1_grant_own0", 32'(grant), 32'd1);
        chk("t1_adr", m_adr_o, 32'h1000);
        chk("t1_we", 32'(m_we_o), 32'd1);
        chk("t1_dat_sm", s0_dat_o, 32'hCAFE_0000);
        n = 0; bad1 = 0;
        while (s0_cyc_i && n < 50) begin
            step(); n++;
            if (s1_ack_o !== 1'b0 || s1_stall_o !== 1'b1) bad1++;
        end
        chk("t1_done", 32'(n < 50), 32'd1);
        chk("t1_acks0", 32'(macks[0]), 32'd10);
        chk("t1_accs0", 32'(maccs[0]), 32'd10);
        chk("t1_m1_blocked", 32'(bad1), 32'd0);
        chk("t1_grant_hold", 32'(grant), 32'd1);
        step();
        chk("t1_grant_rel", 32'(grant), 32'd0);
        chk("t1_mcyc_rel", 32'(m_cyc_o), 32'd0);

        // Simultaneous request straight out of reset.
        do_reset();
        start(0, 4);
        start(1, 4);
        step();
        chk("t2_grant0", 32'(grant), 32'd1);
        wait_drop(0, 50, "t2_drop0");
        chk("t2_grant_hold", 32'(grant), 32'd1);
        step();
        chk("t2_grant_idle", 32'(grant), 32'd0);
        step();
        chk("t2_grant1", 32'(grant), 32'd2);
        chk("t2_adr1", m_adr_o, 32'h2000);
        chk("t2_we1", 32'(m_we_o), 32'd0);
        wait_drop(1, 50, "t2_drop1");
        chk("t2_acks0", 32'(macks[0]), 32'd4);
        chk("t2_acks1", 32'(macks[1]), 32'd4);
        step();

        // Alternating 4-word bursts.
        auto_en[0] = 1'b1; auto_en[1] = 1'b1;
        start(0, 4);
        start(1, 4);
        prev = grant; seen = 0; n = 0;
        while (seen < 4 && n < 200) begin
            step(); n++;
            if (grant !== prev && grant !== 2'b00) begin gl[seen] = grant; seen++; end
            prev = grant;
        end
        chk("t3_seen", 32'(seen), 32'd4);
        chk("t3_g0", 32'(gl[0]), 32'd1);
        chk("t3_g1", 32'(gl[1]), 32'd2);
        chk("t3_g2", 32'(gl[2]), 32'd1);
        chk("t3_g3", 32'(gl[3]), 32'd2);
        auto_en[0] = 1'b0; auto_en[1] = 1'b0;
        n = 0;
        while ((s0_cyc_i || s1_cyc_i) && n < 200) begin step(); n++; end
        chk("t3_quiesce", 32'(n < 200), 32'd1);

        // Preemption of a 200-word hog, ack latency 3.
        do_reset();
        lat = 3;
        start(0, 200);
        n = 0;
        while (maccs[0] < 64 && n < 300) begin
            step(); n++;
            if (n == 5) start(1, 4);
        end
        chk("t4_reach64", 32'(maccs[0]), 32'd64);
        chk("t4_stall0", 32'(s0_stall_o), 32'd1);
        chk("t4_mstb", 32'(m_stb_o), 32'd0);
        chk("t4_grant_drain", 32'(grant), 32'd1);
        a_at = macks[0];
        n = 0;
        while (grant !== 2'b10 && n < 50) begin step(); n++; end
        chk("t4_handover", 32'(grant), 32'd2);
        chk("t4_drain_acks", 32'(macks[0] - a_at), 32'd3);
        chk("t4_acks0_at_ho", 32'(macks[0]), 32'd64);
        chk("t4_slv_accs_at_ho", 32'(slv_accs), 32'd64);
        n = 0;
        while ((s0_cyc_i || s1_cyc_i) && n < 1000) begin step(); n++; end
        chk("t4_finish", 32'(n < 1000), 32'd1);
        chk("t4_acks0", 32'(macks[0]), 32'd200);
        chk("t4_acks1", 32'(macks[1]), 32'd4);
        chk("t4_slv_acks", 32'(slv_acks), 32'd204);

        // Outstanding-transfer saturation with acks withheld.
        do_reset();
        ack_en = 1'b0;
        start(0, 20);
        n = 0;
        while (maccs[0] < 8 && n < 30) begin step(); n++; end
        chk("t5_accs8", 32'(maccs[0]), 32'd8);
        chk("t5_stall_full", 32'(s0_stall_o), 32'd1);
        chk("t5_mstb_full", 32'(m_stb_o), 32'd0);
        step();
        step();
        chk("t5_hold8", 32'(maccs[0]), 32'd8);
        m_ack_i = 1'b1;
        step();
        chk("t5_ack1", 32'(macks[0]), 32'd1);
        chk("t5_stall_open", 32'(s0_stall_o), 32'd0);
        step();
        chk("t5_accs9", 32'(maccs[0]), 32'd9);
        step();
        chk("t5_hold9", 32'(maccs[0]), 32'd9);
        chk("t5_stall_refull", 32'(s0_stall_o), 32'd1);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        ack_en = 1'b1; lat = 3;
        start(0, 100);
        start(1, 4);
        n = 0;
        while (maccs[0] < 64 && n < 200) begin step(); n++; end
        chk("t6_reach64", 32'(maccs[0]), 32'd64);
        step();
        chk("t6_draining_cyc", 32'(m_cyc_o), 32'd1);
        chk("t6_draining_grant", 32'(grant), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_grant", 32'(grant), 32'd0);
        chk("t6_async_mcyc", 32'(m_cyc_o), 32'd0);
        chk("t6_async_stall0", 32'(s0_stall_o), 32'd1);
        chk("t6_async_stall1", 32'(s1_stall_o), 32'd1);
        chk("t6_async_ack0", 32'(s0_ack_o), 32'd0);
        mreset();
        step();
        step();
        rst = 1'b0;
        start(1, 4);
        step();
        chk("t6_resume_grant", 32'(grant), 32'd2);
        wait_drop(1, 50, "t6_resume_drop");
        chk("t6_resume_acks1", 32'(macks[1]), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
